// File: rtl/mem_dbus_if.sv
// Data-bus master for the MEM stage: turns a one-cycle CPU load/store request into a
// Wishbone-style bus cycle, stalling the pipeline until ack, flush or watchdog abort.
module mem_dbus_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        bus_err_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_WAIT_STALL
    } state_t;

    // Last watchdog value before the hung cycle is abandoned.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_wb_we;
    logic [3:0]  r_wb_sel;
    logic        r_wb_stb;
    logic        r_wb_cyc;
    logic        r_bus_err;
    logic [31:0] r_rd_buf;
    logic [7:0]  r_wdog;

    logic [31:0] w_wb_addr;
    logic [31:0] w_wb_data;
    logic        w_wb_we;
    logic [3:0]  w_wb_sel;
    logic        w_wb_stb;
    logic        w_wb_cyc;
    logic        w_bus_err;
    logic [31:0] w_rd_buf;
    logic [7:0]  w_wdog;
    logic        w_release;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        w_state_nxt = r_state;
        w_wb_addr   = r_wb_addr;
        w_wb_data   = r_wb_data;
        w_wb_we     = r_wb_we;
        w_wb_sel    = r_wb_sel;
        w_wb_stb    = r_wb_stb;
        w_wb_cyc    = r_wb_cyc;
        w_bus_err   = 1'b0;
        w_rd_buf    = r_rd_buf;
        w_wdog      = r_wdog;
        w_release   = 1'b0;
        stallreq    = 1'b0;
        cpu_data_o  = '0;

        unique case (r_state)
            S_IDLE: begin
                stallreq = cpu_ce_i & ~flush;
                if (cpu_ce_i && !flush) begin
                    w_wb_addr   = cpu_addr_i;
                    w_wb_data   = cpu_data_i;
                    w_wb_we     = cpu_we_i;
                    w_wb_sel    = cpu_sel_i;
                    w_wb_cyc    = 1'b1;
                    w_wb_stb    = 1'b1;
                    w_wdog      = '0;
                    w_state_nxt = S_BUSY;
                end
            end

            S_BUSY: begin
                if (flush) begin
                    // Flush beats a simultaneous ack: the access is discarded.
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (wb_ack_i) begin
                    cpu_data_o  = cpu_we_i ? '0 : wb_data_i;
                    w_rd_buf    = r_wb_we ? '0 : wb_data_i;
                    w_release   = 1'b1;
                    w_state_nxt = (stall != '0) ? S_WAIT_STALL : S_IDLE;
                end else if (r_wdog == WDOG_LAST) begin
                    w_release   = 1'b1;
                    w_bus_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    stallreq = 1'b1;
                    w_wdog   = r_wdog + 8'd1;
                end
            end

            S_WAIT_STALL: begin
                // Access is done but another stage holds the pipe: keep load data visible.
                cpu_data_o = r_rd_buf;
                if (stall == '0 || flush) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_release) begin
            w_wb_addr = '0;
            w_wb_data = '0;
            w_wb_we   = 1'b0;
            w_wb_sel  = '0;
            w_wb_stb  = 1'b0;
            w_wb_cyc  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_we   <= 1'b0;
            r_wb_sel  <= '0;
            r_wb_stb  <= 1'b0;
            r_wb_cyc  <= 1'b0;
            r_bus_err <= 1'b0;
            r_rd_buf  <= '0;
            r_wdog    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wb_addr <= w_wb_addr;
            r_wb_data <= w_wb_data;
            r_wb_we   <= w_wb_we;
            r_wb_sel  <= w_wb_sel;
            r_wb_stb  <= w_wb_stb;
            r_wb_cyc  <= w_wb_cyc;
            r_bus_err <= w_bus_err;
            r_rd_buf  <= w_rd_buf;
            r_wdog    <= w_wdog;
        end
    end

    assign wb_addr_o = r_wb_addr;
    assign wb_data_o = r_wb_data;
    assign wb_we_o   = r_wb_we;
    assign wb_sel_o  = r_wb_sel;
    assign wb_stb_o  = r_wb_stb;
    assign wb_cyc_o  = r_wb_cyc;
    assign bus_err_o = r_bus_err;

endmodule

// File: tb/tb_mem_dbus_if.sv
// Scoreboard bench for mem_dbus_if: stimulus queues expected bus requests, load
// responses and abort cycles; a negedge monitor pops and compares them.
module tb_mem_dbus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic        bus_err_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    mem_dbus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq   (stallreq),
        .bus_err_o  (bus_err_o),
        .wb_data_i  (wb_data_i),
        .wb_ack_i   (wb_ack_i),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_rsp[$];
    int          exp_err[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc_cnt = 0;
    logic mon_prev_cyc = 1'b0;

    always @(posedge clk) cyc_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc_cnt);
    endtask

    // Monitor: bus cycle start, completed access and abort pulse each consume one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_cyc_o === 1'b1 && !mon_prev_cyc) begin
                if (exp_req.size() == 0) begin
                    fail("mon_unexpected_cyc");
                end else begin
                    req_t r;
                    r = exp_req.pop_front();
                    check("mon_wb_addr", wb_addr_o, r.addr);
                    check("mon_wb_data", wb_data_o, r.data);
                    check("mon_wb_we", 32'(wb_we_o), 32'(r.we));
                    check("mon_wb_sel", 32'(wb_sel_o), 32'(r.sel));
                    check("mon_wb_stb", 32'(wb_stb_o), 32'd1);
                end
            end
            if (wb_cyc_o === 1'b1 && wb_ack_i && !flush) begin
                if (exp_rsp.size() == 0) begin
                    fail("mon_unexpected_rsp");
                end else begin
                    check("mon_cpu_data", cpu_data_o, exp_rsp.pop_front());
                    check("mon_stallreq_ack", 32'(stallreq), 32'd0);
                end
            end
            if (bus_err_o === 1'b1) begin
                if (exp_err.size() == 0) begin
                    fail("mon_unexpected_bus_err");
                end else begin
                    check("mon_bus_err_cycle", 32'(cyc_cnt), 32'(exp_err.pop_front()));
                end
            end
        end
        mon_prev_cyc = (wb_cyc_o === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall      = '0;
        flush      = 1'b0;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = '0;
        cpu_sel_i  = '0;
        cpu_data_i = '0;
        wb_data_i  = '0;
        wb_ack_i   = 1'b0;
    endtask

    // Issues one access with ack after ack_delay extra BUSY cycles; called just after a posedge,
    // returns at the negedge of the cycle after the ack.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] sel,
                             input logic [31:0] rdata, input int ack_delay, input logic [5:0] stall_v);
        int hi;
        req_t r;
        hi = 0;
        r.addr = addr; r.data = data; r.we = we; r.sel = sel;
        exp_req.push_back(r);
        exp_rsp.push_back(we ? 32'h0 : rdata);
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = data; cpu_sel_i = sel;
        @(negedge clk);
        if (stallreq) hi++;
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            @(negedge clk);
            if (stallreq) hi++;
        end
        tick();
        wb_ack_i = 1'b1; wb_data_i = rdata; stall = stall_v;
        @(negedge clk);
        if (stallreq) hi++;
        check({tag, "_stallreq_cycles"}, 32'(hi), 32'(ack_delay + 1));
        tick();
        wb_ack_i = 1'b0; wb_data_i = '0;
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
        @(negedge clk);
        check({tag, "_cyc_released"}, 32'(wb_cyc_o), 32'd0);
        check({tag, "_stb_released"}, 32'(wb_stb_o), 32'd0);
        check({tag, "_addr_cleared"}, wb_addr_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        req_t r;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'd0);
        check("rst_addr", wb_addr_o, 32'd0);
        check("rst_bus_err", 32'(bus_err_o), 32'd0);
        check("rst_stallreq", 32'(stallreq), 32'd0);
        check("rst_cpu_data", cpu_data_o, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Load, ack in the third cycle after the request.
        do_access("load", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 2, 6'b0);
        tick();

        // Store, ack in the first BUSY cycle; read data on the bus must not reach the CPU.
        do_access("store", 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 32'hFFFF_0000, 0, 6'b0);
        tick();

        // Flush in IDLE suppresses the request.
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0044; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_stallreq", 32'(stallreq), 32'd0);
        tick();
        cpu_ce_i = 1'b0; cpu_addr_i = '0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_no_cyc", 32'(wb_cyc_o), 32'd0);
        tick();

        // Flush together with ack in BUSY.
        r.addr = 32'h0000_0050; r.data = 32'h0; r.we = 1'b0; r.sel = 4'hF;
        exp_req.push_back(r);
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0050; cpu_sel_i = 4'hF;
        tick();
        flush = 1'b1; wb_ack_i = 1'b1; wb_data_i = 32'h1111_2222;
        @(negedge clk);
        check("flush_ack_cpu_data", cpu_data_o, 32'd0);
        check("flush_ack_stallreq", 32'(stallreq), 32'd0);
        tick();
        clear_inputs();
        @(negedge clk);
        check("flush_ack_cyc_released", 32'(wb_cyc_o), 32'd0);
        check("flush_ack_idle_stallreq", 32'(stallreq), 32'd0);
        check("flush_ack_idle_data", cpu_data_o, 32'd0);
        tick();

        // Held pipeline: load data stays visible while stall is held; spurious ack ignored.
        do_access("held", 1'b0, 32'h0000_0030, 32'h0, 4'hF, 32'hA5A5_A5A5, 0, 6'b000011);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0040; cpu_sel_i = 4'hF;
                wb_ack_i = (k == 2); wb_data_i = 32'h0BAD_F00D;
                @(negedge clk);
            end
            check("held_cpu_data", cpu_data_o, 32'hA5A5_A5A5);
            check("held_stallreq", 32'(stallreq), 32'd0);
            check("held_no_cyc", 32'(wb_cyc_o), 32'd0);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        check("held_release_data", cpu_data_o, 32'hA5A5_A5A5);
        tick();
        @(negedge clk);
        check("held_idle_data", cpu_data_o, 32'd0);
        tick();

        // Watchdog abort with TIMEOUT_CYCLES=4.
        r.addr = 32'h0000_0060; r.data = 32'h0; r.we = 1'b0; r.sel = 4'hF;
        exp_req.push_back(r);
        exp_err.push_back(cyc_cnt + 5);
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0060; cpu_sel_i = 4'hF; wb_data_i = 32'h7777_7777;
        @(negedge clk);
        check("wdog_req_stallreq", 32'(stallreq), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge clk);
            check("wdog_cyc", 32'(wb_cyc_o), 32'd1);
            check("wdog_stallreq", 32'(stallreq), (k < 4) ? 32'd1 : 32'd0);
            check("wdog_cpu_data", cpu_data_o, 32'd0);
            check("wdog_no_err_yet", 32'(bus_err_o), 32'd0);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        check("wdog_bus_err", 32'(bus_err_o), 32'd1);
        check("wdog_cyc_dropped", 32'(wb_cyc_o), 32'd0);
        tick();
        @(negedge clk);
        check("wdog_bus_err_pulse", 32'(bus_err_o), 32'd0);
        tick();

        // Reset two cycles into a load.
        r.addr = 32'h0000_0070; r.data = 32'h0; r.we = 1'b0; r.sel = 4'hF;
        exp_req.push_back(r);
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0070; cpu_sel_i = 4'hF;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check("rst_busy_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_busy_stb", 32'(wb_stb_o), 32'd0);
        check("rst_busy_addr", wb_addr_o, 32'd0);
        check("rst_busy_stallreq", 32'(stallreq), 32'd0);
        check("rst_busy_bus_err", 32'(bus_err_o), 32'd0);
        tick();
        do_access("post_rst", 1'b1, 32'h0000_0080, 32'hCAFE_0001, 4'b1100, 32'h5555_AAAA, 1, 6'b0);
        tick();
        tick();

        check("left_req", 32'(exp_req.size()), 32'd0);
        check("left_rsp", 32'(exp_rsp.size()), 32'd0);
        check("left_err", 32'(exp_err.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_dbus_if.md
Name: mem_dbus_if

Overview:
- Data-bus master for the memory-access stage; sits between the MEM-stage load/store logic and the Wishbone-style data bus.
- Converts a single-cycle CPU data request into a multi-cycle bus transaction.
- Holds the pipeline via stallreq until the bus acknowledges, then presents read data as mem-stage load data feeding the MEM/WB register.
- Honours pipeline flush and global stall, and aborts hung transactions with a watchdog.

Parameters:
- TIMEOUT_CYCLES, 255: max BUSY cycles without wb_ack_i before abort; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- stall  in  6  pipeline stall vector from ctrl; any bit set = pipeline held
- flush  in  1  pipeline flush (exception)
- cpu_ce_i  in  1  MEM-stage data access request
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address
- cpu_sel_i  in  4  byte lane select
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data to MEM stage
- stallreq  out  1  stall request to ctrl
- bus_err_o  out  1  one-cycle pulse on watchdog abort
- wb_data_i  in  32  bus read data
- wb_ack_i  in  1  bus acknowledge
- wb_addr_o  out  32  bus address
- wb_data_o  out  32  bus write data
- wb_we_o  out  1  bus write enable
- wb_sel_o  out  4  bus byte select
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle valid

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, watchdog=0, rd_buf=0.
  - All wb_* outputs 0, bus_err_o=0.
  - Combinational outputs in IDLE with cpu_ce_i=0: stallreq=0, cpu_data_o=0.
- Registered: wb_*_o, bus_err_o, rd_buf, watchdog counter (8 bit).
- Combinational: stallreq, cpu_data_o.
- IDLE:
  - cpu_ce_i=1 and flush=0: on posedge latch wb_addr_o/wb_data_o/wb_we_o/wb_sel_o from cpu_*, set wb_cyc_o=wb_stb_o=1, watchdog=0, go BUSY.
  - stallreq=cpu_ce_i & ~flush; cpu_data_o=0.
- BUSY:
  - wb_ack_i=1 and flush=0:
    - cpu_data_o = cpu_we_i ? 0 : wb_data_i; stallreq=0.
    - On posedge: clear wb_cyc_o, wb_stb_o, wb_we_o; wb_sel_o=0, wb_addr_o=0, wb_data_o=0.
    - rd_buf <= wb_data_i for a load (cpu_data_o stays 0 for a store).
    - Next state: WAIT_STALL if stall!=0, else IDLE.
  - flush=1 (with or without ack): stallreq=0, cpu_data_o=0; on posedge drop all wb_* to 0, discard data, go IDLE. Flush wins over ack.
  - Otherwise, no ack and watchdog==TIMEOUT_CYCLES-1: stallreq=0, cpu_data_o=0; on posedge drop wb_* to 0, bus_err_o=1 for one cycle, go IDLE.
  - Otherwise: stallreq=1, cpu_data_o=0, watchdog+1.
- WAIT_STALL (completed access, pipeline still held by another stage):
  - stallreq=0, cpu_data_o=rd_buf (0 for a store).
  - No new bus cycle starts.
  - stall==0 or flush=1: go IDLE next cycle.
- bus_err_o: 0 in every cycle except the one following an abort.
- Latency:
  - Request at cycle N → cyc/stb high at N+1.
  - Ack at cycle M → data on cpu_data_o and stallreq low in cycle M (combinational), bus released at M+1.
  - Minimum held-stall length: 1 cycle (ack at N+1).
- Back-to-back: after return to IDLE, a still-asserted cpu_ce_i (next instruction) starts a new cycle immediately. No idle bubble on the bus is required beyond the one-cycle cyc low.
- wb_* inputs are ignored outside BUSY. A spurious ack in IDLE or WAIT_STALL has no effect.
- Reset mid-transaction: next posedge forces IDLE and all outputs to reset values. No ack is waited for.

Test Plan:
- Load, ack 3 cycles after cyc: cpu_ce_i=1, we=0, addr=0x0000_0010, sel=4'hF, wb_data_i=0xDEAD_BEEF → stallreq high 3 cycles, low in the ack cycle with cpu_data_o=0xDEADBEEF, cyc/stb low next cycle.
- Store, ack 1 cycle after cyc: addr=0x0000_0020, data=0x1234_5678, sel=4'b0011 → wb_we_o=1, wb_data_o=0x12345678, wb_sel_o=3 while cyc=1; cpu_data_o=0; stallreq high exactly 1 cycle.
- Flush in BUSY together with ack: flush=1 and wb_ack_i=1 in the same cycle → cpu_data_o=0, bus released next cycle, state IDLE, no data captured.
- Held pipeline: ack with stall=6'b000011 held 4 more cycles, load data 0xA5A5_A5A5 → cpu_data_o=0xA5A5A5A5 for all 4 cycles, stallreq=0, no new cyc.
- Watchdog: TIMEOUT_CYCLES=4, no ack → cyc high 4 cycles, stallreq drops in cycle 4, bus_err_o=1 exactly one cycle after, cpu_data_o=0.
- Reset mid-BUSY: rst=1 two cycles into a load → all wb_* 0, stallreq=0, bus_err_o=0 after the posedge; a later request starts cleanly.
